// File: rtl/axi_write_pkg.sv
// Shared types for the AXI-style write slave: FSM state encoding and response codes.
package axi_write_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_RESP  = 2'b10
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_write_slave.sv
// Write-only slave: captures address and data beats independently, strobes the register core once, then responds.
// Define AXI_WR_ADDR_CHECK_EN to reject unaligned or out-of-range addresses with SLVERR.
module axi_write_slave
    import axi_write_pkg::*;
#(
    parameter int data_width_g = 32,
    parameter int num_regs_g   = 4,
    localparam int IDX_W       = ($clog2(num_regs_g) > 0) ? $clog2(num_regs_g) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    waddr_valid,
    output logic                    waddr_ready,
    input  logic [data_width_g-1:0] waddr_data,
    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    input  logic [data_width_g-1:0] wdata_data,
    output logic                    wresp_valid,
    input  logic                    wresp_ready,
    output logic [1:0]              wresp_data,
    output logic                    reg_wr_en,
    output logic [IDX_W-1:0]        reg_wr_idx,
    output logic [data_width_g-1:0] reg_wr_data
);

    state_t                  r_state;
    logic                    r_addr_held;
    logic                    r_data_held;
    logic [data_width_g-1:0] r_addr;
    logic [data_width_g-1:0] r_data;
    logic                    r_legal;
    logic                    r_waddr_ready;
    logic                    r_wdata_ready;
    logic                    r_wresp_valid;
    logic [1:0]              r_wresp_data;
    logic                    r_reg_wr_en;
    logic [IDX_W-1:0]        r_reg_wr_idx;
    logic [data_width_g-1:0] r_reg_wr_data;

    logic                    w_addr_hs;
    logic                    w_data_hs;
    logic                    w_addr_held_nxt;
    logic                    w_data_held_nxt;
    logic [data_width_g-1:0] w_addr_nxt;
    logic [data_width_g-1:0] w_data_nxt;
    logic [data_width_g-1:0] w_word;
    logic                    w_legal;

    // Readies are only ever high in IDLE, so a handshake implies IDLE.
    assign w_addr_hs       = waddr_valid & r_waddr_ready;
    assign w_data_hs       = wdata_valid & r_wdata_ready;
    assign w_addr_held_nxt = r_addr_held | w_addr_hs;
    assign w_data_held_nxt = r_data_held | w_data_hs;
    assign w_addr_nxt      = w_addr_hs ? waddr_data : r_addr;
    assign w_data_nxt      = w_data_hs ? wdata_data : r_data;
    assign w_word          = w_addr_nxt >> 2;

`ifdef AXI_WR_ADDR_CHECK_EN
    assign w_legal = (w_addr_nxt[1:0] == 2'b00) && (w_word < data_width_g'(num_regs_g));
`else
    logic w_unused_addr_bits;
    assign w_legal            = 1'b1;
    assign w_unused_addr_bits = ^{w_addr_nxt[1:0], w_word[data_width_g-1:IDX_W]};
`endif

    // Transaction FSM with holding registers and registered channel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_addr_held   <= 1'b0;
            r_data_held   <= 1'b0;
            r_addr        <= {data_width_g{1'b0}};
            r_data        <= {data_width_g{1'b0}};
            r_legal       <= 1'b0;
            r_waddr_ready <= 1'b1;
            r_wdata_ready <= 1'b1;
            r_wresp_valid <= 1'b0;
            r_wresp_data  <= RESP_OKAY;
            r_reg_wr_en   <= 1'b0;
            r_reg_wr_idx  <= {IDX_W{1'b0}};
            r_reg_wr_data <= {data_width_g{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_addr_held <= w_addr_held_nxt;
                    r_data_held <= w_data_held_nxt;
                    r_addr      <= w_addr_nxt;
                    r_data      <= w_data_nxt;
                    if (w_addr_held_nxt && w_data_held_nxt) begin
                        r_state       <= ST_WRITE;
                        r_waddr_ready <= 1'b0;
                        r_wdata_ready <= 1'b0;
                        r_legal       <= w_legal;
                        r_reg_wr_en   <= w_legal;
                        r_reg_wr_idx  <= w_legal ? w_word[IDX_W-1:0] : {IDX_W{1'b0}};
                        r_reg_wr_data <= w_legal ? w_data_nxt : {data_width_g{1'b0}};
                    end else begin
                        r_waddr_ready <= ~w_addr_held_nxt;
                        r_wdata_ready <= ~w_data_held_nxt;
                    end
                end
                ST_WRITE: begin
                    r_state       <= ST_RESP;
                    r_reg_wr_en   <= 1'b0;
                    r_reg_wr_idx  <= {IDX_W{1'b0}};
                    r_reg_wr_data <= {data_width_g{1'b0}};
                    r_wresp_valid <= 1'b1;
                    r_wresp_data  <= r_legal ? RESP_OKAY : RESP_SLVERR;
                end
                ST_RESP: begin
                    // Outputs simply hold while the master stalls the response.
                    if (wresp_ready) begin
                        r_state       <= ST_IDLE;
                        r_addr_held   <= 1'b0;
                        r_data_held   <= 1'b0;
                        r_wresp_valid <= 1'b0;
                        r_wresp_data  <= RESP_OKAY;
                        r_waddr_ready <= 1'b1;
                        r_wdata_ready <= 1'b1;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_addr_held   <= 1'b0;
                    r_data_held   <= 1'b0;
                    r_waddr_ready <= 1'b1;
                    r_wdata_ready <= 1'b1;
                    r_wresp_valid <= 1'b0;
                    r_wresp_data  <= RESP_OKAY;
                    r_reg_wr_en   <= 1'b0;
                    r_reg_wr_idx  <= {IDX_W{1'b0}};
                    r_reg_wr_data <= {data_width_g{1'b0}};
                end
            endcase
        end
    end

    assign waddr_ready = r_waddr_ready;
    assign wdata_ready = r_wdata_ready;
    assign wresp_valid = r_wresp_valid;
    assign wresp_data  = r_wresp_data;
    assign reg_wr_en   = r_reg_wr_en;
    assign reg_wr_idx  = r_reg_wr_idx;
    assign reg_wr_data = r_reg_wr_data;

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed self-checking bench for axi_write_slave; expectations follow AXI_WR_ADDR_CHECK_EN when defined.
module tb_axi_write_slave;

    logic        clk;
    logic        rst_n;
    logic        waddr_valid;
    logic        waddr_ready;
    logic [31:0] waddr_data;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata_data;
    logic        wresp_valid;
    logic        wresp_ready;
    logic [1:0]  wresp_data;
    logic        reg_wr_en;
    logic [1:0]  reg_wr_idx;
    logic [31:0] reg_wr_data;

    int vectors;
    int miscompares;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    logic [39:0] obs;
    assign obs = {waddr_ready, wdata_ready, wresp_valid, wresp_data, reg_wr_en, reg_wr_idx, reg_wr_data};

    axi_write_slave #(
        .data_width_g(32),
        .num_regs_g  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .waddr_valid(waddr_valid),
        .waddr_ready(waddr_ready),
        .waddr_data (waddr_data),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .wdata_data (wdata_data),
        .wresp_valid(wresp_valid),
        .wresp_ready(wresp_ready),
        .wresp_data (wresp_data),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_idx (reg_wr_idx),
        .reg_wr_data(reg_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word: {waddr_ready, wdata_ready, wresp_valid, wresp_data, reg_wr_en, idx, data}
    function automatic logic [39:0] ex(input logic ar, input logic dr, input logic rv, input logic [1:0] rd,
                                       input logic en, input logic [1:0] idx, input logic [31:0] d);
        return {ar, dr, rv, rd, en, idx, d};
    endfunction

    localparam logic [39:0] V_IDLE = {1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
    localparam logic [39:0] V_RESP_OK = {1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'h0};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; waddr_valid = 1'b0; wdata_valid = 1'b0; wresp_ready = 1'b0;
        waddr_data = 32'h0; wdata_data = 32'h0;
        tick(); tick();
        vectors++; if (obs !== V_IDLE) begin miscompares++; $display("FAIL reset_hold: got %h want %h", obs, V_IDLE); end
        rst_n = 1'b1;
        tick();
        vectors++; if (obs !== V_IDLE) begin miscompares++; $display("FAIL post_reset_idle: got %h want %h", obs, V_IDLE); end
    endtask

    task automatic test_same_cycle();
        logic [39:0] e;
        waddr_valid = 1'b1; waddr_data = 32'h8; wdata_valid = 1'b1; wdata_data = 32'hCAFEBABE; wresp_ready = 1'b1;
        tick();
        e = ex(1'b0, 1'b0, 1'b0, OK, 1'b1, 2'd2, 32'hCAFEBABE);
        vectors++; if (obs !== e) begin miscompares++; $display("FAIL same_cycle_strobe: got %h want %h", obs, e); end
        waddr_valid = 1'b0; wdata_valid = 1'b0;
        tick();
        vectors++; if (obs !== V_RESP_OK) begin miscompares++; $display("FAIL same_cycle_resp: got %h want %h", obs, V_RESP_OK); end
        tick();
        vectors++; if (obs !== V_IDLE) begin miscompares++; $display("FAIL same_cycle_idle: got %h want %h", obs, V_IDLE); end
    endtask

    task automatic test_data_first();
        logic [39:0] e;
        int n_strobe;
        n_strobe = 0;
        wresp_ready = 1'b1;
        wdata_valid = 1'b1; wdata_data = 32'h11;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (reg_wr_en === 1'b1) n_strobe++;
            e = ex(1'b1, 1'b0, 1'b0, OK, 1'b0, 2'd0, 32'h0);
            vectors++; if (obs !== e) begin miscompares++; $display("FAIL data_first_wait c%0d: got %h want %h", c, obs, e); end
            wdata_data = 32'h22;
            if (c == 3) begin waddr_valid = 1'b1; waddr_data = 32'h4; end
        end
        tick();
        if (reg_wr_en === 1'b1) n_strobe++;
        e = ex(1'b0, 1'b0, 1'b0, OK, 1'b1, 2'd1, 32'h11);
        vectors++; if (obs !== e) begin miscompares++; $display("FAIL data_first_strobe: got %h want %h", obs, e); end
        waddr_valid = 1'b0; wdata_valid = 1'b0;
        tick();
        if (reg_wr_en === 1'b1) n_strobe++;
        vectors++; if (obs !== V_RESP_OK) begin miscompares++; $display("FAIL data_first_resp: got %h want %h", obs, V_RESP_OK); end
        tick();
        if (reg_wr_en === 1'b1) n_strobe++;
        vectors++; if (n_strobe !== 1) begin miscompares++; $display("FAIL data_first_strobe_count: got %0d want 1", n_strobe); end
    endtask

    task automatic test_addr_check();
        logic [31:0] addrs [2];
        logic [31:0] datas [2];
        logic [39:0] ew [2];
        logic [39:0] er [2];
        addrs[0] = 32'h10; datas[0] = 32'hAA;
        addrs[1] = 32'h6;  datas[1] = 32'hBB;
`ifdef AXI_WR_ADDR_CHECK_EN
        ew[0] = ex(1'b0, 1'b0, 1'b0, OK, 1'b0, 2'd0, 32'h0);  er[0] = ex(1'b0, 1'b0, 1'b1, ERR, 1'b0, 2'd0, 32'h0);
        ew[1] = ex(1'b0, 1'b0, 1'b0, OK, 1'b0, 2'd0, 32'h0);  er[1] = ex(1'b0, 1'b0, 1'b1, ERR, 1'b0, 2'd0, 32'h0);
`else
        ew[0] = ex(1'b0, 1'b0, 1'b0, OK, 1'b1, 2'd0, 32'hAA); er[0] = V_RESP_OK;
        ew[1] = ex(1'b0, 1'b0, 1'b0, OK, 1'b1, 2'd1, 32'hBB); er[1] = V_RESP_OK;
`endif
        wresp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            waddr_valid = 1'b1; waddr_data = addrs[i]; wdata_valid = 1'b1; wdata_data = datas[i];
            tick();
            vectors++; if (obs !== ew[i]) begin miscompares++; $display("FAIL addr_check_write a=%h: got %h want %h", addrs[i], obs, ew[i]); end
            waddr_valid = 1'b0; wdata_valid = 1'b0;
            tick();
            vectors++; if (obs !== er[i]) begin miscompares++; $display("FAIL addr_check_resp a=%h: got %h want %h", addrs[i], obs, er[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [39:0] e;
        wresp_ready = 1'b0;
        waddr_valid = 1'b1; waddr_data = 32'hC; wdata_valid = 1'b1; wdata_data = 32'h5A5A5A5A;
        tick();
        e = ex(1'b0, 1'b0, 1'b0, OK, 1'b1, 2'd3, 32'h5A5A5A5A);
        vectors++; if (obs !== e) begin miscompares++; $display("FAIL stall_strobe: got %h want %h", obs, e); end
        waddr_valid = 1'b0; wdata_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++; if (obs !== V_RESP_OK) begin miscompares++; $display("FAIL stall_resp c%0d: got %h want %h", c, obs, V_RESP_OK); end
        end
        wresp_ready = 1'b1;
        tick();
        vectors++; if (obs !== V_IDLE) begin miscompares++; $display("FAIL stall_release_idle: got %h want %h", obs, V_IDLE); end
    endtask

    task automatic test_second_addr();
        logic [39:0] e;
        wresp_ready = 1'b1;
        waddr_valid = 1'b1; waddr_data = 32'h0;
        tick();
        e = ex(1'b0, 1'b1, 1'b0, OK, 1'b0, 2'd0, 32'h0);
        vectors++; if (obs !== e) begin miscompares++; $display("FAIL second_addr_held: got %h want %h", obs, e); end
        waddr_data = 32'h4;
        tick();
        vectors++; if (obs !== e) begin miscompares++; $display("FAIL second_addr_blocked: got %h want %h", obs, e); end
        wdata_valid = 1'b1; wdata_data = 32'h1;
        tick();
        e = ex(1'b0, 1'b0, 1'b0, OK, 1'b1, 2'd0, 32'h1);
        vectors++; if (obs !== e) begin miscompares++; $display("FAIL second_addr_first_write: got %h want %h", obs, e); end
        wdata_valid = 1'b0;
        tick();
        vectors++; if (obs !== V_RESP_OK) begin miscompares++; $display("FAIL second_addr_resp1: got %h want %h", obs, V_RESP_OK); end
        tick();
        vectors++; if (obs !== V_IDLE) begin miscompares++; $display("FAIL second_addr_idle: got %h want %h", obs, V_IDLE); end
        wdata_valid = 1'b1; wdata_data = 32'h2;
        tick();
        e = ex(1'b0, 1'b0, 1'b0, OK, 1'b1, 2'd1, 32'h2);
        vectors++; if (obs !== e) begin miscompares++; $display("FAIL second_addr_next_write: got %h want %h", obs, e); end
        waddr_valid = 1'b0; wdata_valid = 1'b0;
        tick();
        vectors++; if (obs !== V_RESP_OK) begin miscompares++; $display("FAIL second_addr_resp2: got %h want %h", obs, V_RESP_OK); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [39:0] e;
        wresp_ready = 1'b1;
        waddr_valid = 1'b1; waddr_data = 32'h8; wdata_valid = 1'b1; wdata_data = 32'h1;
        tick();
        e = ex(1'b0, 1'b0, 1'b0, OK, 1'b1, 2'd2, 32'h1);
        vectors++; if (obs !== e) begin miscompares++; $display("FAIL rst_write_entry: got %h want %h", obs, e); end
        waddr_valid = 1'b0; wdata_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++; if (obs !== V_IDLE) begin miscompares++; $display("FAIL rst_in_write: got %h want %h", obs, V_IDLE); end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (obs !== V_IDLE) begin miscompares++; $display("FAIL rst_write_after c%0d: got %h want %h", c, obs, V_IDLE); end
        end
        wresp_ready = 1'b0;
        waddr_valid = 1'b1; waddr_data = 32'h4; wdata_valid = 1'b1; wdata_data = 32'h2;
        tick();
        waddr_valid = 1'b0; wdata_valid = 1'b0;
        tick();
        vectors++; if (obs !== V_RESP_OK) begin miscompares++; $display("FAIL rst_resp_entry: got %h want %h", obs, V_RESP_OK); end
        rst_n = 1'b0;
        #1;
        vectors++; if (obs !== V_IDLE) begin miscompares++; $display("FAIL rst_in_resp: got %h want %h", obs, V_IDLE); end
        wresp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (obs !== V_IDLE) begin miscompares++; $display("FAIL rst_resp_after c%0d: got %h want %h", c, obs, V_IDLE); end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_same_cycle();
        test_data_first();
        test_addr_check();
        test_backpressure();
        test_second_addr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_write_slave.md
AXI_WRITE_SLAVE -- requirements
Module: axi_write_slave

Interface
REQ-001 Parameter data_width_g, default 32, width of address and write-data payloads.
REQ-002 Parameter num_regs_g, default 4, number of word registers addressable in the consuming core.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 waddr_valid  input  1  write-address channel valid.
REQ-006 waddr_ready  output  1  write-address channel ready.
REQ-007 waddr_data  input  data_width_g  byte address.
REQ-008 wdata_valid  input  1  write-data channel valid.
REQ-009 wdata_ready  output  1  write-data channel ready.
REQ-010 wdata_data  input  data_width_g  write payload.
REQ-011 wresp_valid  output  1  write-response channel valid.
REQ-012 wresp_ready  input  1  write-response channel ready.
REQ-013 wresp_data  output  2  response code, OKAY=2'b00, SLVERR=2'b10.
REQ-014 reg_wr_en  output  1  one-cycle write strobe to core.
REQ-015 reg_wr_idx  output  $clog2(num_regs_g)  register index.
REQ-016 reg_wr_data  output  data_width_g  register write value.

Function
REQ-017 Handshake on a channel SHALL occur when valid and ready are both high at a rising clk edge.
REQ-018 FSM SHALL have states IDLE, WRITE, RESP.
REQ-019 IDLE: waddr_ready = !addr_held, wdata_ready = !data_held; each channel captured independently into its own holding register, in either order or same cycle.
REQ-020 A second address (or data) beat SHALL NOT be accepted while one is already held.
REQ-021 IDLE->WRITE on the edge where both holds become/are set; if both handshakes happen in cycle N, WRITE is cycle N+1.
REQ-022 WRITE: lasts exactly one cycle; both readies low; reg_wr_en=1 only if the held address is legal; reg_wr_idx = addr>>2; reg_wr_data = held data.
REQ-023 WRITE->RESP unconditionally; wresp_valid first high in cycle N+2.
REQ-024 RESP: wresp_valid=1, wresp_data stable (OKAY if legal, SLVERR if not) until wresp_ready handshake; both readies low.
REQ-025 RESP->IDLE on response handshake; holds cleared on that edge; new beats acceptable the following cycle.
REQ-026 wresp_ready held low indefinitely SHALL stall the block in RESP with no loss or change of outputs.
REQ-027 reg_wr_en SHALL be low in all states except WRITE; reg_wr_idx/reg_wr_data SHALL be 0 when reg_wr_en is low.

Reset
REQ-028 On rst_n low: state=IDLE, holds cleared, waddr_ready=1, wdata_ready=1, wresp_valid=0, wresp_data=0, reg_wr_en=0, reg_wr_idx=0, reg_wr_data=0.
REQ-029 Reset asserted mid-transaction (any state) SHALL abandon it: no strobe, no response after release.

Configuration
REQ-030 Macro AXI_WR_ADDR_CHECK_EN defined: address legal only if addr[1:0]==0 and addr>>2 < num_regs_g; illegal gives SLVERR and no strobe.
REQ-031 AXI_WR_ADDR_CHECK_EN undefined: every address legal, reg_wr_idx = (addr>>2) truncated to index width, response always OKAY.

Structure
REQ-032 Shared package axi_write_pkg SHALL hold the FSM state enum and response constants RESP_OKAY, RESP_SLVERR.
REQ-033 No sub-module; holding registers and FSM in one module.

Verification
REQ-034 addr 0x8 and data 0xCAFEBABE same cycle N -> strobe idx 2 data 0xCAFEBABE at N+1, wresp OKAY at N+2.
REQ-035 data 0x11 at cycle 0, addr 0x4 at cycle 3 -> wdata_ready low cycles 1-3, strobe idx 1 at cycle 4, single strobe.
REQ-036 With check enabled, addr 0x10 (num_regs_g=4) and addr 0x6 -> no strobe, wresp_data 2'b10 each.
REQ-037 wresp_ready low 10 cycles in RESP -> wresp_valid/wresp_data stable, both readies low, no second strobe.
REQ-038 Second addr offered while addr held -> not accepted until after response handshake; executes as next transaction.
REQ-039 rst_n pulsed low during WRITE or RESP -> all outputs at reset values, no response issued afterwards.
